// File: rtl/bitonic_pkg.sv
// Shared helpers for the bitonic merge pipeline: size derivation and lane slicing.
package bitonic_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int n2_of(input int n_per_side);
    return 2 * n_per_side;
  endfunction

  function automatic int stages_of(input int n_per_side);
    return clog2(2 * n_per_side);
  endfunction

  // Low bit of lane k in a packed vector of w-bit lanes.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

  localparam int N_PER_SIDE_DEFAULT = 16;
  localparam int N2                 = n2_of(N_PER_SIDE_DEFAULT);
  localparam int STAGES             = stages_of(N_PER_SIDE_DEFAULT);

endpackage

// File: rtl/bitonic_cas.sv
// Registered compare-exchange cell: preferred key to o_lo, swap only on strict inequality.
module bitonic_cas #(
  parameter int W       = 32,
  parameter int KEY_W   = 32,
  parameter bit DESCEND = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi
);

  logic [KEY_W-1:0] key_a;
  logic [KEY_W-1:0] key_b;
  logic             swap;

  always_comb begin
    key_a = i_a[W-1 -: KEY_W];
    key_b = i_b[W-1 -: KEY_W];
    swap  = DESCEND ? (key_a < key_b) : (key_a > key_b);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_lo <= '0;
      o_hi <= '0;
    end else if (i_en) begin
      o_lo <= swap ? i_b : i_a;
      o_hi <= swap ? i_a : i_b;
    end
  end

endmodule

// File: rtl/bitonic_merge_pipe.sv
// Fully pipelined bitonic merger of two sorted vectors with valid/ready flow control
// and a user sideband travelling alongside the data.
module bitonic_merge_pipe
  import bitonic_pkg::*;
#(
  parameter int N_PER_SIDE = 16,
  parameter int W          = 32,
  parameter int KEY_W      = 32,
  parameter int USER_W     = 1,
  parameter bit DESCEND    = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [N_PER_SIDE*W-1:0] i_elems_0,
  input  logic [N_PER_SIDE*W-1:0] i_elems_1,
  input  logic [USER_W-1:0]       i_user,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [N_PER_SIDE*W-1:0] o_elems_0,
  output logic [N_PER_SIDE*W-1:0] o_elems_1,
  output logic [USER_W-1:0]       o_user
);

  localparam int          LANES = n2_of(N_PER_SIDE);
  localparam int unsigned NSTG  = stages_of(N_PER_SIDE);

  logic              en;
  logic [NSTG:1]     v;
  logic [USER_W-1:0] user_q [1:NSTG];
  logic [W-1:0]      lane_q [1:NSTG][LANES];

  // Global enable: the whole pipe stalls together, bubbles included.
  assign en      = ~v[NSTG] | i_ready;
  assign o_ready = en;
  assign o_valid = v[NSTG];
  assign o_user  = user_q[NSTG];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v <= '0;
      for (int unsigned s = 1; s <= NSTG; s++) user_q[s] <= '0;
    end else if (en) begin
      v         <= {v[NSTG-1:1], i_valid};
      user_q[1] <= i_user;
      for (int unsigned s = 2; s <= NSTG; s++) user_q[s] <= user_q[s-1];
    end
  end

  generate
    // First stage compares A[k] against B reversed, turning two sorted runs into a bitonic one.
    for (genvar k = 0; k < N_PER_SIDE; k++) begin : g_s1
      bitonic_cas #(.W(W), .KEY_W(KEY_W), .DESCEND(DESCEND)) u_cas (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (en),
        .i_a   (i_elems_0[lane_lo(k, W) +: W]),
        .i_b   (i_elems_1[lane_lo(N_PER_SIDE-1-k, W) +: W]),
        .o_lo  (lane_q[1][k]),
        .o_hi  (lane_q[1][LANES-1-k])
      );
    end

    for (genvar s = 2; s <= int'(NSTG); s++) begin : g_stg
      localparam int D = LANES >> s;
      for (genvar p = 0; p < N_PER_SIDE; p++) begin : g_cas
        localparam int LO = (p / D) * 2 * D + (p % D);
        bitonic_cas #(.W(W), .KEY_W(KEY_W), .DESCEND(DESCEND)) u_cas (
          .i_clk (i_clk),
          .i_rst (i_rst),
          .i_en  (en),
          .i_a   (lane_q[s-1][LO]),
          .i_b   (lane_q[s-1][LO+D]),
          .o_lo  (lane_q[s][LO]),
          .o_hi  (lane_q[s][LO+D])
        );
      end
    end

    for (genvar k = 0; k < N_PER_SIDE; k++) begin : g_out
      assign o_elems_0[lane_lo(k, W) +: W] = lane_q[NSTG][k];
      assign o_elems_1[lane_lo(k, W) +: W] = lane_q[NSTG][N_PER_SIDE+k];
    end
  endgenerate

endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// Directed bench for bitonic_merge_pipe across small, tie, descending and default configs.
module tb_bitonic_merge_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // N=4, W=8 ascending
  logic a_iv, a_or, a_ov, a_ir;
  logic [31:0] a_i0, a_i1, a_o0, a_o1;
  logic [0:0] a_iu, a_ou;
  // N=2, W=8, KEY_W=4
  logic t_iv, t_or, t_ov, t_ir;
  logic [15:0] t_i0, t_i1, t_o0, t_o1;
  logic [0:0] t_iu, t_ou;
  // N=4, W=8 descending
  logic d_iv, d_or, d_ov, d_ir;
  logic [31:0] d_i0, d_i1, d_o0, d_o1;
  logic [0:0] d_iu, d_ou;
  // default N=16, W=32, USER_W=4
  logic b_iv, b_or, b_ov, b_ir;
  logic [511:0] b_i0, b_i1, b_o0, b_o1;
  logic [3:0] b_iu, b_ou;

  bitonic_merge_pipe #(.N_PER_SIDE(4), .W(8), .KEY_W(8), .USER_W(1), .DESCEND(1'b0)) u_asc (
    .i_clk(clk), .i_rst(rst), .i_valid(a_iv), .o_ready(a_or), .i_elems_0(a_i0), .i_elems_1(a_i1),
    .i_user(a_iu), .o_valid(a_ov), .i_ready(a_ir), .o_elems_0(a_o0), .o_elems_1(a_o1), .o_user(a_ou));

  bitonic_merge_pipe #(.N_PER_SIDE(2), .W(8), .KEY_W(4), .USER_W(1), .DESCEND(1'b0)) u_tie (
    .i_clk(clk), .i_rst(rst), .i_valid(t_iv), .o_ready(t_or), .i_elems_0(t_i0), .i_elems_1(t_i1),
    .i_user(t_iu), .o_valid(t_ov), .i_ready(t_ir), .o_elems_0(t_o0), .o_elems_1(t_o1), .o_user(t_ou));

  bitonic_merge_pipe #(.N_PER_SIDE(4), .W(8), .KEY_W(8), .USER_W(1), .DESCEND(1'b1)) u_desc (
    .i_clk(clk), .i_rst(rst), .i_valid(d_iv), .o_ready(d_or), .i_elems_0(d_i0), .i_elems_1(d_i1),
    .i_user(d_iu), .o_valid(d_ov), .i_ready(d_ir), .o_elems_0(d_o0), .o_elems_1(d_o1), .o_user(d_ou));

  bitonic_merge_pipe #(.USER_W(4)) u_big (
    .i_clk(clk), .i_rst(rst), .i_valid(b_iv), .o_ready(b_or), .i_elems_0(b_i0), .i_elems_1(b_i1),
    .i_user(b_iu), .o_valid(b_ov), .i_ready(b_ir), .o_elems_0(b_o0), .o_elems_1(b_o1), .o_user(b_ou));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat b: merged result is base+j in lane j; inputs either interleave or concatenate.
  function automatic logic [511:0] mk_a(input int unsigned b);
    logic [511:0] r;
    int unsigned base;
    base = b * 1000 + 5;
    for (int unsigned k = 0; k < 16; k++) r[k*32 +: 32] = (b % 2 == 0) ? base + 2*k : base + k;
    return r;
  endfunction

  function automatic logic [511:0] mk_b(input int unsigned b);
    logic [511:0] r;
    int unsigned base;
    base = b * 1000 + 5;
    for (int unsigned k = 0; k < 16; k++) r[k*32 +: 32] = (b % 2 == 0) ? base + 2*k + 1 : base + 16 + k;
    return r;
  endfunction

  function automatic logic [511:0] exp_half(input int unsigned b, input int unsigned off);
    logic [511:0] r;
    int unsigned base;
    base = b * 1000 + 5 + off;
    for (int unsigned j = 0; j < 16; j++) r[j*32 +: 32] = base + j;
    return r;
  endfunction

  task automatic pulse_a(input logic [31:0] x0, input logic [31:0] x1);
    a_i0 = x0; a_i1 = x1; a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (a_ov !== 1'b0) begin miscompares++; $display("FAIL reset_a_valid: got %b, want 0", a_ov); end
    vectors++; if (a_or !== 1'b1) begin miscompares++; $display("FAIL reset_a_ready: got %b, want 1", a_or); end
    vectors++; if ({a_o0, a_o1, a_ou} !== '0) begin miscompares++; $display("FAIL reset_a_data: got %h %h %b, want 0", a_o0, a_o1, a_ou); end
    vectors++; if (b_ov !== 1'b0 || b_or !== 1'b1 || b_ou !== 4'h0) begin miscompares++; $display("FAIL reset_b_ctrl: got v=%b r=%b u=%h, want 0 1 0", b_ov, b_or, b_ou); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_merge_basic();
    pulse_a(32'h07050301, 32'h08060402);
    tick();
    vectors++; if (a_ov !== 1'b0) begin miscompares++; $display("FAIL basic_early: got o_valid %b, want 0", a_ov); end
    tick();
    vectors++; if (a_ov !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b, want 1", a_ov); end
    vectors++; if (a_o0 !== 32'h04030201 || a_o1 !== 32'h08070605) begin miscompares++; $display("FAIL basic_data: got %h %h, want 04030201 08070605", a_o0, a_o1); end
    tick();
    vectors++; if (a_ov !== 1'b0) begin miscompares++; $display("FAIL basic_drop: got %b, want 0", a_ov); end
  endtask

  task automatic test_merge_skewed();
    pulse_a(32'h09090909, 32'h04030201);
    tick(); tick();
    vectors++; if (a_ov !== 1'b1 || a_o0 !== 32'h04030201 || a_o1 !== 32'h09090909) begin miscompares++; $display("FAIL skew_data: got v=%b %h %h, want 1 04030201 09090909", a_ov, a_o0, a_o1); end
    tick();
  endtask

  task automatic test_ties();
    t_i0 = 16'h1A10; t_i1 = 16'h1F13; t_iv = 1'b1;
    tick();
    t_iv = 1'b0;
    tick();
    vectors++; if (t_ov !== 1'b1 || t_o0 !== 16'h1A10 || t_o1 !== 16'h1F13) begin miscompares++; $display("FAIL tie_equal: got v=%b %h %h, want 1 1a10 1f13", t_ov, t_o0, t_o1); end
    // Keys 2,3 vs 2,4: only the upper nibble orders, low nibbles ride along.
    t_i0 = 16'h302F; t_i1 = 16'h412A; t_iv = 1'b1;
    tick();
    t_iv = 1'b0;
    tick();
    vectors++; if (t_ov !== 1'b1 || t_o0 !== 16'h2A2F || t_o1 !== 16'h4130) begin miscompares++; $display("FAIL tie_keyonly: got v=%b %h %h, want 1 2a2f 4130", t_ov, t_o0, t_o1); end
    tick();
  endtask

  task automatic test_descend();
    d_i0 = 32'h02040608; d_i1 = 32'h01030507; d_iv = 1'b1;
    tick();
    d_iv = 1'b0;
    tick(); tick();
    vectors++; if (d_ov !== 1'b1 || d_o0 !== 32'h05060708 || d_o1 !== 32'h01020304) begin miscompares++; $display("FAIL desc_data: got v=%b %h %h, want 1 05060708 01020304", d_ov, d_o0, d_o1); end
    tick();
  endtask

  task automatic test_back_to_back();
    a_iv = 1'b1;
    a_i0 = 32'h07050301; a_i1 = 32'h08060402; a_iu = 1'b1; tick();
    a_i0 = 32'h09090909; a_i1 = 32'h04030201; a_iu = 1'b0; tick();
    a_i0 = 32'h281E140A; a_i1 = 32'h2D23190F; a_iu = 1'b1; tick();
    a_iv = 1'b0;
    vectors++; if (a_ov !== 1'b1 || a_o0 !== 32'h04030201 || a_o1 !== 32'h08070605 || a_ou !== 1'b1) begin miscompares++; $display("FAIL b2b_0: got v=%b %h %h u=%b, want 1 04030201 08070605 1", a_ov, a_o0, a_o1, a_ou); end
    tick();
    vectors++; if (a_ov !== 1'b1 || a_o0 !== 32'h04030201 || a_o1 !== 32'h09090909 || a_ou !== 1'b0) begin miscompares++; $display("FAIL b2b_1: got v=%b %h %h u=%b, want 1 04030201 09090909 0", a_ov, a_o0, a_o1, a_ou); end
    tick();
    vectors++; if (a_ov !== 1'b1 || a_o0 !== 32'h19140F0A || a_o1 !== 32'h2D28231E || a_ou !== 1'b1) begin miscompares++; $display("FAIL b2b_2: got v=%b %h %h u=%b, want 1 19140f0a 2d28231e 1", a_ov, a_o0, a_o1, a_ou); end
    tick();
    vectors++; if (a_ov !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b, want 0", a_ov); end
  endtask

  task automatic test_backpressure();
    int unsigned in_idx = 0;
    int unsigned out_idx = 0;
    logic held = 1'b0;
    logic accept;
    logic [511:0] h0, h1;
    logic [3:0] hu;
    for (int unsigned cyc = 0; cyc < 80 && out_idx < 10; cyc++) begin
      b_ir = !(cyc >= 6 && cyc < 10);
      b_iv = (in_idx < 10);
      b_i0 = mk_a(in_idx); b_i1 = mk_b(in_idx); b_iu = 4'(in_idx + 1);
      #1;
      if (b_ov && !b_ir) begin
        vectors++; if (b_or !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b, want 0 at cycle %0d", b_or, cyc); end
        if (held) begin
          vectors++; if (b_o0 !== h0 || b_o1 !== h1 || b_ou !== hu) begin miscompares++; $display("FAIL bp_hold: got %h u=%h, want %h u=%h", b_o0[63:0], b_ou, h0[63:0], hu); end
        end
        h0 = b_o0; h1 = b_o1; hu = b_ou; held = 1'b1;
      end else begin
        held = 1'b0;
      end
      if (b_ov && b_ir) begin
        vectors++;
        if (b_o0 !== exp_half(out_idx, 0) || b_o1 !== exp_half(out_idx, 16) || b_ou !== 4'(out_idx + 1)) begin
          miscompares++;
          $display("FAIL bp_beat%0d: got lo=%h hi=%h u=%h, want lo=%h hi=%h u=%h", out_idx, b_o0[63:0], b_o1[63:0], b_ou, exp_half(out_idx, 0) >> 0, exp_half(out_idx, 16) >> 0, 4'(out_idx + 1));
        end
        out_idx++;
      end
      accept = b_iv && b_or;
      @(posedge clk);
      #1;
      if (accept) in_idx++;
    end
    b_iv = 1'b0; b_ir = 1'b1;
    vectors++; if (out_idx != 10) begin miscompares++; $display("FAIL bp_count: got %0d beats, want 10", out_idx); end
    tick(); tick();
    vectors++; if (b_ov !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup: got o_valid %b, want 0", b_ov); end
  endtask

  task automatic test_reset_inflight();
    b_ir = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      b_iv = 1'b1; b_i0 = mk_a(20 + i); b_i1 = mk_b(20 + i); b_iu = 4'(i + 1);
      tick();
    end
    b_iv = 1'b0;
    vectors++; if (b_ov !== 1'b1) begin miscompares++; $display("FAIL rst_pre_valid: got %b, want 1", b_ov); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (b_ov !== 1'b0 || b_or !== 1'b1) begin miscompares++; $display("FAIL rst_ctrl: got v=%b r=%b, want 0 1", b_ov, b_or); end
    vectors++; if (b_o0 !== '0 || b_o1 !== '0 || b_ou !== 4'h0) begin miscompares++; $display("FAIL rst_data: got %h %h u=%h, want 0", b_o0[63:0], b_o1[63:0], b_ou); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_iv = 1'b1; b_i0 = mk_a(30); b_i1 = mk_b(30); b_iu = 4'hA;
    tick();
    b_iv = 1'b0;
    for (int unsigned i = 1; i < bitonic_pkg::STAGES; i++) begin
      vectors++; if (b_ov !== 1'b0) begin miscompares++; $display("FAIL rst_stale: got o_valid %b after %0d edges, want 0", b_ov, i); end
      tick();
    end
    vectors++;
    if (b_ov !== 1'b1 || b_o0 !== exp_half(30, 0) || b_o1 !== exp_half(30, 16) || b_ou !== 4'hA) begin
      miscompares++;
      $display("FAIL rst_new_beat: got v=%b lo=%h u=%h, want 1 lo=%h u=a", b_ov, b_o0[63:0], b_ou, exp_half(30, 0) >> 0);
    end
    tick();
    vectors++; if (b_ov !== 1'b0) begin miscompares++; $display("FAIL rst_after: got %b, want 0", b_ov); end
  endtask

  initial begin
    rst = 1'b1;
    a_iv = 0; a_ir = 1; a_i0 = '0; a_i1 = '0; a_iu = '0;
    t_iv = 0; t_ir = 1; t_i0 = '0; t_i1 = '0; t_iu = '0;
    d_iv = 0; d_ir = 1; d_i0 = '0; d_i1 = '0; d_iu = '0;
    b_iv = 0; b_ir = 1; b_i0 = '0; b_i1 = '0; b_iu = '0;
    test_reset();
    test_merge_basic();
    test_merge_skewed();
    test_ties();
    test_descend();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitonic_merge_pipe.md
Name: bitonic_merge_pipe

Overview:
- Parametrised, fully pipelined bitonic merger with two inputs. Each input is a sorted vector of N_PER_SIDE elements; the block emits the merged sorted vector of 2*N_PER_SIDE elements.
- Successor to the fixed 32+32 merger. Generalised in element width, lane count, key field and sort direction.
- Adds a valid/ready handshake, per-stage valid bits, async reset, and a USER_W sideband carried with the data. Sits between the per-leaf sorters and the output coupler in the merge tree.

Parameters:
- N_PER_SIDE, 16, elements per input vector; power of 2, >=2.
- W, 32, element width in bits.
- KEY_W, 32, compare key width; key = element bits [W-1 : W-KEY_W]; KEY_W <= W.
- USER_W, 1, sideband width (switch flag, top tuple, etc.), carried unmodified.
- DESCEND, 0, 0 = ascending (lane 0 smallest); 1 = descending (lane 0 largest).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept an input beat this cycle
- i_elems_0  in  N_PER_SIDE*W  sorted vector A; lane k at [(k+1)*W-1 : k*W]
- i_elems_1  in  N_PER_SIDE*W  sorted vector B; same order and direction as A
- i_user  in  USER_W  sideband for this beat
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the output beat
- o_elems_0  out  N_PER_SIDE*W  lower half of merged result (lanes 0..N-1)
- o_elems_1  out  N_PER_SIDE*W  upper half of merged result (lanes N..2N-1)
- o_user  out  USER_W  sideband aligned with o_elems

Behaviour:
- Constants:
  - N2 = 2*N_PER_SIDE.
  - STAGES = log2(N2).
  - Latency = STAGES cycles from accepted input to o_valid, with no backpressure.
- Stage 1 (reverse-compare):
  - For k in 0..N-1: compare A[k] with B[N-1-k].
  - The smaller key (larger if DESCEND) goes to lane k; the other goes to lane N2-1-k.
- Stage s, for s = 2..STAGES:
  - Distance d = N2 >> s.
  - Within each block of 2d lanes, lane i is compare-exchanged with lane i+d, min to the lower lane.
- Compare rules:
  - Unsigned compare on the key field only.
  - Swap only on strict inequality; equal keys keep their positions.
  - Non-key bits travel with their element.
- Pipelining:
  - Every stage is registered: element data, stage valid v[s], and the user sideband.
  - o_valid = v[STAGES]; o_elems and o_user come from the last stage registers.
- Flow control (global enable):
  - en = ~o_valid | i_ready; o_ready = en, combinational.
  - When en = 1: all stages shift, v[1] <= i_valid, and data and user are captured.
  - When en = 0: all stage registers hold, including bubbles. No bubble collapsing.
  - Data registers load only when en = 1. Capture while i_valid = 0 is allowed but don't-care, since the valid bit is 0.
- Input handshake: a beat is accepted iff i_valid & o_ready.
  - i_valid held with o_ready = 0 -> the beat is not consumed and the upstream must hold it stable.
- Output handshake: o_valid & i_ready -> beat consumed.
  - o_valid held with i_ready = 0 -> o_elems and o_user remain stable.
- Throughput: 1 beat/cycle while i_ready = 1.
- Reset (async assert, released on the clock edge by the system synchroniser):
  - All v[s] = 0, all data and user registers = 0.
  - o_valid = 0, o_elems_0 = o_elems_1 = 0, o_user = 0, o_ready = 1.
  - Reset mid-operation discards all in-flight beats.
- Input precondition: A and B must be sorted in the DESCEND direction; unsorted input gives an unspecified permutation (no error flag).
- Width rule: element width is preserved; no arithmetic. KEY_W == W means the whole element is the key.

Decomposition:
- Shared package bitonic_pkg:
  - function clog2.
  - localparams N2 and STAGES derived from N_PER_SIDE.
  - Lane-slice helper macro/function for [(k+1)*W-1 : k*W].
- Sub-module bitonic_cas:
  - Params W, KEY_W, DESCEND.
  - Ports i_clk, i_rst, i_en, i_a, i_b, o_lo, o_hi; registered, async reset to 0.
- Top level instantiates one bitonic_cas grid per stage via generate, plus the v[] and user shift chain.

Test Plan:
- N_PER_SIDE=4, W=8: A=[1,3,5,7], B=[2,4,6,8], i_ready=1 -> after 3 cycles o_valid=1, o_elems_0=[1,2,3,4], o_elems_1=[5,6,7,8].
- Same config with A=[9,9,9,9], B=[1,2,3,4]:
  - expect o_elems_0=[1,2,3,4], o_elems_1=[9,9,9,9].
  - Ties: W=8, KEY_W=4, A lanes=0x10,0x1A, B lanes=0x13,0x1F (N=2) -> all keys equal, so no swaps occur and the output order equals the stage-1 layout, [0x10,0x1A,0x13,0x1F] after 2 cycles.
- DESCEND=1, N=4: A=[8,6,4,2], B=[7,5,3,1] -> o_elems_0=[8,7,6,5], o_elems_1=[4,3,2,1].
- Backpressure at default N=16:
  - Stream 10 back-to-back beats with distinct i_user values; hold i_ready=0 for 4 cycles mid-stream.
  - Expect o_ready=0 while o_valid=1 and the outputs stay stable.
  - Expect all 10 beats out in order, correctly merged, each with its matching o_user, and none lost or duplicated.
- Assert i_rst with 3 beats in flight -> o_valid drops to 0 immediately, all outputs read 0, o_ready=1. After release, a new beat appears exactly STAGES cycles later with no stale data.
